// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The slave modport is the controller's view; the master modport is the datapath's.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] resultSrc;
  logic [2:0] aluControl;
  logic       adrSrc;
  logic       irWrite;
  logic       pcWrite;
  logic       regWrite;
  logic       memWrite;
  logic       done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output op, funct3, funct7b5, zero,
    input  immSrc, aluSrcA, aluSrcB, resultSrc, aluControl, adrSrc,
           irWrite, pcWrite, regWrite, memWrite, done, illegal, state
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output immSrc, aluSrcA, aluSrcB, resultSrc, aluControl, adrSrc,
           irWrite, pcWrite, regWrite, memWrite, done, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences one instruction at
// a time and drives all datapath selects, write enables and the ALU control.
module multicycle_controller (
  input logic                   clk,
  input logic                   rst_n,
  multicycle_controller_if.slave bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;
  logic       op_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_legal = 1'b1;
      default:                                  op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      // Codes 11-15 are unreachable; recover through FETCH.
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.aluSrcA   = 2'b00;
    bus.aluSrcB   = 2'b00;
    bus.resultSrc = 2'b00;
    bus.adrSrc    = 1'b0;
    bus.irWrite   = 1'b0;
    bus.regWrite  = 1'b0;
    bus.memWrite  = 1'b0;
    bus.done      = 1'b0;
    bus.illegal   = 1'b0;
    alu_op        = 2'b00;
    branch        = 1'b0;
    pc_update     = 1'b0;
    case (state_q)
      FETCH: begin
        bus.irWrite   = 1'b1;
        bus.aluSrcB   = 2'b10;
        bus.resultSrc = 2'b10;
        pc_update     = 1'b1;
      end
      DECODE: begin
        bus.aluSrcA = 2'b01;
        bus.aluSrcB = 2'b01;
        bus.illegal = ~op_legal;
        bus.done    = ~op_legal;
      end
      MEMADR: begin
        bus.aluSrcA = 2'b10;
        bus.aluSrcB = 2'b01;
      end
      MEMREAD: bus.adrSrc = 1'b1;
      MEMWB: begin
        bus.resultSrc = 2'b01;
        bus.regWrite  = 1'b1;
        bus.done      = 1'b1;
      end
      MEMWRITE: begin
        bus.adrSrc   = 1'b1;
        bus.memWrite = 1'b1;
        bus.done     = 1'b1;
      end
      EXECUTER: begin
        bus.aluSrcA = 2'b10;
        alu_op      = 2'b10;
      end
      EXECUTEI: begin
        bus.aluSrcA = 2'b10;
        bus.aluSrcB = 2'b01;
        alu_op      = 2'b10;
      end
      ALUWB: begin
        bus.regWrite = 1'b1;
        bus.done     = 1'b1;
      end
      BEQ: begin
        bus.aluSrcA = 2'b10;
        alu_op      = 2'b01;
        branch      = 1'b1;
        bus.done    = 1'b1;
      end
      JAL: begin
        bus.aluSrcA = 2'b01;
        bus.aluSrcB = 2'b10;
        pc_update   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pcWrite = pc_update | (branch & bus.zero);
  assign bus.state   = state_q;

  always_comb begin
    bus.aluControl = 3'b000;
    case (alu_op)
      2'b01: bus.aluControl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.aluControl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.aluControl = 3'b101;
          3'b110:  bus.aluControl = 3'b011;
          3'b111:  bus.aluControl = 3'b010;
          default: bus.aluControl = 3'b000;
        endcase
      end
      default: bus.aluControl = 3'b000;
    endcase
  end

  always_comb begin
    bus.immSrc = 2'b00;
    case (bus.op)
      OP_SW:   bus.immSrc = 2'b01;
      OP_BEQ:  bus.immSrc = 2'b10;
      OP_JAL:  bus.immSrc = 2'b11;
      default: bus.immSrc = 2'b00;
    endcase
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core; it sequences the shared ALU, memory port, register file and immediate extender across one instruction at a time. It takes opcode/funct fields from the instruction register plus the ALU `zero` flag and drives every datapath select and write-enable. It also drives the 2-bit immediate-format select consumed by the immediate extender. Supported set: lw, sw, R-type ALU, I-type ALU, beq, jal; any other opcode is flagged illegal and skipped.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU result == 0.
- `immSrc`  out  2  00 I, 01 S, 10 B, 11 J.
- `aluSrcA`  out  2  00 PC, 01 oldPC, 10 rs1 data.
- `aluSrcB`  out  2  00 rs2 data, 01 immExt, 10 constant 4.
- `resultSrc`  out  2  00 ALUOut reg, 01 memory data reg, 10 ALU result.
- `aluControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `adrSrc`  out  1  0 PC, 1 result bus.
- `irWrite`, `pcWrite`, `regWrite`, `memWrite`  out  1 each  write enables.
- `done`  out  1  last cycle of an instruction.
- `illegal`  out  1  unsupported opcode seen in DECODE.
- `state`  out  4  current state code (debug).

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11-15 are unreachable; if entered, the next state is FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw/sw -> MEMADR; R -> EXECUTER; I -> EXECUTEI; beq -> BEQ; jal -> JAL; any other opcode -> FETCH, with `illegal`=1 and `done`=1 in that cycle.
  - MEMADR: lw -> MEMREAD, otherwise -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER, EXECUTEI, JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH.
- Moore outputs per state; any output not listed is 0:
  - FETCH: irWrite=1, aluSrcB=10, resultSrc=10, pcUpdate=1.
  - DECODE: aluSrcA=01, aluSrcB=01 (branch target precompute).
  - MEMADR: aluSrcA=10, aluSrcB=01.
  - MEMREAD: adrSrc=1.
  - MEMWB: resultSrc=01, regWrite=1.
  - MEMWRITE: adrSrc=1, memWrite=1.
  - EXECUTER: aluSrcA=10, aluOp=10.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10.
  - ALUWB: regWrite=1.
  - BEQ: aluSrcA=10, aluOp=01, branch=1.
  - JAL: aluSrcA=01, aluSrcB=10, pcUpdate=1.
- `pcWrite` = pcUpdate | (branch & zero). This is the only output that depends on `zero`.
- ALU decoder (combinational):
  - aluOp 00 -> add; aluOp 01 -> sub.
  - aluOp 10, funct3 000 -> sub if (op[5] & funct7b5), else add.
  - aluOp 10, funct3 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- `immSrc` is decoded from `op` only, independent of state: lw/I/R -> 00, sw -> 01, beq -> 10, jal -> 11, other -> 00.
- `done` = 1 in MEMWB, MEMWRITE, ALUWB, BEQ, and in the illegal DECODE cycle.

## Timing
- Reset: `rst_n` low forces state=FETCH immediately, without waiting for a clock edge. Outputs then show FETCH values: irWrite=1, pcWrite=1, aluSrcB=10, resultSrc=10, all other outputs 0.
- Reset asserted mid-instruction aborts it; no write enable other than the FETCH values is driven while reset is low.
- First FETCH after reset release is the cycle containing the first rising edge with `rst_n` high.
- Latency in cycles, FETCH through the final state inclusive: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- A new FETCH always follows the `done` cycle; no overlap between instructions.
- `op`, `funct3` and `funct7b5` must be stable from DECODE until `done`. The instruction register is written only in FETCH, which guarantees this.
- All outputs are combinational from state and inputs. They are valid within the cycle and are sampled by datapath registers at the next rising edge.

## Test plan
- Reset mid-MEMREAD -> `state` reads 0 asynchronously; irWrite=1, pcWrite=1, memWrite=0, regWrite=0.
- lw (op 0000011) -> states 0,1,2,3,4; MEMWB has regWrite=1 and resultSrc=01; `done` is high only in cycle 5; immSrc=00.
- sw (op 0100011) -> states 0,1,2,5; memWrite=1 and adrSrc=1 only in cycle 4; immSrc=01; regWrite never 1.
- beq with zero=1, then again with zero=0 -> BEQ cycle: pcWrite=1 and pcWrite=0 respectively; aluControl=001 in both; latency 3; immSrc=10.
- R-type with funct3=000, funct7b5=1 -> EXECUTER aluControl=001. Same fields with I-type op 0010011 -> aluControl=000. R-type with funct3=010 -> 101, 110 -> 011, 111 -> 010.
- jal, then opcode 0110111 -> jal: states 0,1,10,8 with pcWrite=1 in JAL and immSrc=11. Illegal opcode: states 0,1,0 with illegal=1 and done=1 in DECODE, and no write enables asserted.
